id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised, registered instruction-decode stage for the 5-stage pipeline. It decodes one 32-bit instruction per cycle and reads operands from an internal register file with a write-back port. It detects load-use hazards against the instruction currently in EX. Results are registered into the ID/EX pipeline register, with support for hold, flush and bubble insertion. It sits between the IF/ID register and the EX stage.

## Interface
- `XLEN`, 32: datapath width; 16-bit immediate sign-extended to `XLEN`.
- `NREG`, 32: register count, power of two ≥ 2; `AW = $clog2(NREG)`, register fields use the low `AW` bits of the 5-bit fields.
- `clk` in 1: single clock; everything on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_valid` in 1: IF/ID holds a real instruction.
- `pc_in` in 32: PC of the instruction.
- `inst` in 32: instruction; opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].
- `wb_en` in 1: write-back enable.
- `wb_addr` in 5: write-back register.
- `wb_value` in XLEN: write-back data.
- `hold` in 1: downstream stall; ID/EX keeps its contents.
- `flush` in 1: taken branch; squash the instruction in ID.
- `stall` out 1: IF/ID and PC must not advance; `hold | load_use`.
- `ex_valid` out 1: registered; ID/EX holds a real instruction.
- `ex_pc` out 32: registered PC.
- `ex_wb_en` out 1: registered write-back enable.
- `ex_mem_read` out 1: registered memory-read control.
- `ex_mem_write` out 1: registered memory-write control.
- `ex_br` out 2: registered branch type; 00 none, 01 BEZ, 10 BNE, 11 JMP.
- `ex_cmd` out 4: registered EX command.
- `ex_val1` out XLEN: registered rs value.
- `ex_val2` out XLEN: registered rt value or sign-extended immediate.
- `ex_st_val` out XLEN: registered raw rt value, used for ST and branch compare.
- `ex_dest` out 5: registered destination.
- `ex_src1` out 5: registered rs, for the forwarding unit.
- `ex_src2` out 5: registered rt, for the forwarding unit.
- `ex_src2_used` out 1: registered; rt is a real source.

## Operation
- Decode, combinational from `opcode`:
  - produces wb_en, mem_read, mem_write, br, cmd, is_imm and src2_used.
  - Unknown opcode decodes as NOP: all controls 0, cmd 0000.
- Destination is rt when is_imm, else rd. `val2` is imm_sext when is_imm, else rt value.
- Register file:
  - `NREG`×`XLEN`, two combinational read ports and one write port.
  - Write at the clock edge when `wb_en` is set and `wb_addr` ≠ 0.
  - Register 0 always reads 0.
  - Reset clears all entries.
- Load-use hazard: `load_use = if_valid & ex_valid & ex_mem_read & ex_dest≠0 & (ex_dest==rs | (src2_used & ex_dest==rt))`.
- ID/EX update, priority high to low:
  - `rst`: all outputs 0.
  - `hold`: retain all contents.
  - `flush`: bubble.
  - `load_use` or `!if_valid`: bubble.
  - Otherwise: load the decoded instruction with `ex_valid=1`.
- Bubble means every ex_* field is 0, including `ex_valid`, controls and data.
- `flush` does not assert `stall`.

## Timing
- Decode-to-EX latency is 1 cycle.
- Throughput is 1 instruction/cycle when there is no stall.
- `stall` is combinational in the same cycle.
- `load_use` costs exactly 1 bubble: the next cycle `ex_mem_read`=0, so the hazard clears.
- `hold` with `load_use` together: hold wins and `stall`=1.
- `flush` with `load_use` together: bubble, `stall`=1.
- Write-back to `rs`/`rt` in the same cycle as decode: see Configuration.
- `rst` asserted mid-stream clears ID/EX and the register file on that edge.

## Configuration
- `ID_WB_BYPASS_EN` defined: a read port whose address equals `wb_addr` while `wb_en` is set and the address ≠ 0 returns `wb_value` in the same cycle. This lets WB and ID overlap with no extra stall.
- `ID_WB_BYPASS_EN` undefined: reads return the pre-write value. The hazard unit or compiler must cover the one-cycle gap.

## Structure
- Package `id_pkg` holds:
  - opcode constants: NOP 0, ADD 1, SUB 3, AND 5, OR 6, NOR 7, XOR 8, SLA 9, SLL 10, SRA 11, SRL 12, ADDI 32, SUBI 33, LD 36, ST 37, BEZ 40, BNE 41, JMP 42.
  - EX command constants: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SLA/SLL 1000, SRA 1001, SRL 1010.
  - br codes.
  - the control-bundle struct.
- ADDI/LD/ST use the ADD command; SUBI uses SUB.
- src2_used is set for R-type, ST and BNE.
- One sub-module: `id_regfile`, which holds the `NREG`/`XLEN` parameters and the bypass macro.

## Test plan
- Reset, then `if_valid=1`, ADD r3,r1,r2 with r1=5, r2=7 pre-written. Next cycle: `ex_valid=1`, `ex_cmd=0000`, `ex_val1=5`, `ex_val2=7`, `ex_dest=3`, `ex_wb_en=1`.
- ADDI r4,r1,-1 (imm 0xFFFF). Next cycle: `ex_val2=32'hFFFFFFFF`, `ex_dest=4`, `ex_src2_used=0`.
- LD r5 followed by ADD r6,r5,r1. `stall=1` for one cycle and one bubble (`ex_valid=0`). The ADD then issues with `ex_src1=5`. LD r0 followed by a use of r0 gives no stall.
- `flush=1` with a valid SUB in ID gives bubble next cycle. `hold=1` for 3 cycles keeps all `ex_*` outputs unchanged and `stall=1`.
- Write `wb_addr=2`, `wb_value=0xAA` while decoding a read of r2:
  - with `ID_WB_BYPASS_EN`: `ex_val2=0xAA`;
  - without it: the old value, then 0xAA on the next decode.
- `wb_en` to r0 with 0xFF, then read r0 gives 0. Reset mid-stream zeroes all outputs and registers.

Source files
------------

// File: rtl/id_pkg.sv
// id_pkg: opcode and EX command constants, branch codes and the decode control bundle
// shared by the decode stage and its register file.
package id_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_SLA  = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRA  = 6'd11;
  localparam logic [5:0] OP_SRL  = 6'd12;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SHL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  typedef struct packed {
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] br;
    logic [3:0] cmd;
    logic       is_imm;
    logic       src2_used;
  } ctrl_t;

  // Branches carry their offset in val2; BNE compares rs against rt via the raw rt value.
  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.wb_en = 1'b1; c.cmd = CMD_ADD; c.src2_used = 1'b1; end
      OP_SUB:  begin c.wb_en = 1'b1; c.cmd = CMD_SUB; c.src2_used = 1'b1; end
      OP_AND:  begin c.wb_en = 1'b1; c.cmd = CMD_AND; c.src2_used = 1'b1; end
      OP_OR:   begin c.wb_en = 1'b1; c.cmd = CMD_OR;  c.src2_used = 1'b1; end
      OP_NOR:  begin c.wb_en = 1'b1; c.cmd = CMD_NOR; c.src2_used = 1'b1; end
      OP_XOR:  begin c.wb_en = 1'b1; c.cmd = CMD_XOR; c.src2_used = 1'b1; end
      OP_SLA,
      OP_SLL:  begin c.wb_en = 1'b1; c.cmd = CMD_SHL; c.src2_used = 1'b1; end
      OP_SRA:  begin c.wb_en = 1'b1; c.cmd = CMD_SRA; c.src2_used = 1'b1; end
      OP_SRL:  begin c.wb_en = 1'b1; c.cmd = CMD_SRL; c.src2_used = 1'b1; end
      OP_ADDI: begin c.wb_en = 1'b1; c.cmd = CMD_ADD; c.is_imm = 1'b1; end
      OP_SUBI: begin c.wb_en = 1'b1; c.cmd = CMD_SUB; c.is_imm = 1'b1; end
      OP_LD:   begin c.wb_en = 1'b1; c.mem_read = 1'b1; c.cmd = CMD_ADD; c.is_imm = 1'b1; end
      OP_ST:   begin c.mem_write = 1'b1; c.cmd = CMD_ADD; c.is_imm = 1'b1; c.src2_used = 1'b1; end
      OP_BEZ:  begin c.br = BR_BEZ; c.is_imm = 1'b1; end
      OP_BNE:  begin c.br = BR_BNE; c.is_imm = 1'b1; c.src2_used = 1'b1; end
      OP_JMP:  begin c.br = BR_JMP; c.is_imm = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: NREG x XLEN register file, two combinational reads, one write, r0 hardwired to 0.
// Macro ID_WB_BYPASS_EN forwards a same-cycle write to a matching read port.
module id_regfile
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem_r [NREG];
  logic            wr_s;

  assign wr_s = wen && (waddr != {AW{1'b0}});

  // Storage: cleared by reset, written on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem_r[i] <= {XLEN{1'b0}};
    end else if (wr_s) begin
      mem_r[waddr] <= wdata;
    end else begin
      mem_r[waddr] <= mem_r[waddr];
    end
  end

  // Read ports.
  always_comb begin
    rdata1 = {XLEN{1'b0}};
    rdata2 = {XLEN{1'b0}};
    if (raddr1 == {AW{1'b0}}) rdata1 = {XLEN{1'b0}};
`ifdef ID_WB_BYPASS_EN
    else if (wr_s && (waddr == raddr1)) rdata1 = wdata;
`endif
    else rdata1 = mem_r[raddr1];
    if (raddr2 == {AW{1'b0}}) rdata2 = {XLEN{1'b0}};
`ifdef ID_WB_BYPASS_EN
    else if (wr_s && (waddr == raddr2)) rdata2 = wdata;
`endif
    else rdata2 = mem_r[raddr2];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode, operand read, load-use detection and the ID/EX register.
// Optional macro ID_WB_BYPASS_EN enables same-cycle write-back forwarding in id_regfile.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     pc_in,
  input  logic [31:0]     inst,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_value,
  input  logic            hold,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic            ex_wb_en,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [1:0]      ex_br,
  output logic [3:0]      ex_cmd,
  output logic [XLEN-1:0] ex_val1,
  output logic [XLEN-1:0] ex_val2,
  output logic [XLEN-1:0] ex_st_val,
  output logic [4:0]      ex_dest,
  output logic [4:0]      ex_src1,
  output logic [4:0]      ex_src2,
  output logic            ex_src2_used
);

  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    ctrl_t           ctrl;
    logic [XLEN-1:0] val1;
    logic [XLEN-1:0] val2;
    logic [XLEN-1:0] st_val;
    logic [4:0]      dest;
    logic [4:0]      src1;
    logic [4:0]      src2;
  } id_ex_t;

  ctrl_t           ctrl_s;
  logic [4:0]      rs_s, rt_s, rd_s;
  logic [XLEN-1:0] rs_val_s, rt_val_s, imm_sext_s;
  logic            load_use_s;
  id_ex_t          ex_next_s, ex_r;

  assign ctrl_s     = decode(inst[31:26]);
  assign rs_s       = 5'(inst[21 +: AW]);
  assign rt_s       = 5'(inst[16 +: AW]);
  assign rd_s       = 5'(inst[11 +: AW]);
  assign imm_sext_s = {{(XLEN-16){inst[15]}}, inst[15:0]};

  id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs_s[AW-1:0]),
    .raddr2 (rt_s[AW-1:0]),
    .rdata1 (rs_val_s),
    .rdata2 (rt_val_s),
    .wen    (wb_en),
    .waddr  (wb_addr[AW-1:0]),
    .wdata  (wb_value)
  );

  assign load_use_s = if_valid && ex_r.valid && ex_r.ctrl.mem_read && (ex_r.dest != 5'd0) &&
                      ((ex_r.dest == rs_s) || (ctrl_s.src2_used && (ex_r.dest == rt_s)));
  assign stall      = hold || load_use_s;

  // Next ID/EX contents: a bubble is an all-zero record.
  always_comb begin
    ex_next_s = '0;
    if (flush || load_use_s || !if_valid) begin
      ex_next_s = '0;
    end else begin
      ex_next_s.valid  = 1'b1;
      ex_next_s.pc     = pc_in;
      ex_next_s.ctrl   = ctrl_s;
      ex_next_s.val1   = rs_val_s;
      ex_next_s.val2   = ctrl_s.is_imm ? imm_sext_s : rt_val_s;
      ex_next_s.st_val = rt_val_s;
      ex_next_s.dest   = ctrl_s.is_imm ? rt_s : rd_s;
      ex_next_s.src1   = rs_s;
      ex_next_s.src2   = rt_s;
    end
  end

  // ID/EX register; hold outranks flush and hazards.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (hold) begin
      ex_r <= ex_r;
    end else begin
      ex_r <= ex_next_s;
    end
  end

  assign ex_valid     = ex_r.valid;
  assign ex_pc        = ex_r.pc;
  assign ex_wb_en     = ex_r.ctrl.wb_en;
  assign ex_mem_read  = ex_r.ctrl.mem_read;
  assign ex_mem_write = ex_r.ctrl.mem_write;
  assign ex_br        = ex_r.ctrl.br;
  assign ex_cmd       = ex_r.ctrl.cmd;
  assign ex_val1      = ex_r.val1;
  assign ex_val2      = ex_r.val2;
  assign ex_st_val    = ex_r.st_val;
  assign ex_dest      = ex_r.dest;
  assign ex_src1      = ex_r.src1;
  assign ex_src2      = ex_r.src2;
  assign ex_src2_used = ex_r.ctrl.src2_used;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed plan items followed by randomized traffic.
module tb_id_stage_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst, if_valid, wb_en, hold, flush;
  logic [31:0] pc_in, inst;
  logic [4:0] wb_addr;
  logic [XLEN-1:0] wb_value;
  logic stall, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write, ex_src2_used;
  logic [31:0] ex_pc;
  logic [1:0] ex_br;
  logic [3:0] ex_cmd;
  logic [XLEN-1:0] ex_val1, ex_val2, ex_st_val;
  logic [4:0] ex_dest, ex_src1, ex_src2;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_in(pc_in), .inst(inst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_value(wb_value), .hold(hold), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_wb_en(ex_wb_en),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_br(ex_br), .ex_cmd(ex_cmd),
    .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_st_val(ex_st_val), .ex_dest(ex_dest),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_src2_used(ex_src2_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic valid; logic [31:0] pc; logic wb, mr, mw; logic [1:0] br; logic [3:0] cmd;
    logic [XLEN-1:0] v1, v2, st; logic [4:0] dest, s1, s2; logic s2u;
  } exp_t;

  exp_t q[$];
  exp_t m_ex;
  logic [XLEN-1:0] m_rf [NREG];
  bit m_known = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] pc_cnt = 32'h0000_1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction semantics from the opcode table, grouped by instruction class.
  function automatic void model_decode(input int op, output bit wb, mr, mw, imm, s2,
                                       output logic [1:0] br, output logic [3:0] cmd);
    wb = 0; mr = 0; mw = 0; imm = 0; s2 = 0; br = 2'd0; cmd = 4'd0;
    if (op inside {1, 3, 5, 6, 7, 8, 9, 10, 11, 12}) begin
      wb = 1; s2 = 1;
      case (op)
        3: cmd = 4'd2;  5: cmd = 4'd4;  6: cmd = 4'd5;  7: cmd = 4'd6;  8: cmd = 4'd7;
        9, 10: cmd = 4'd8;  11: cmd = 4'd9;  12: cmd = 4'd10;
        default: cmd = 4'd0;
      endcase
    end else if (op inside {32, 33, 36, 37}) begin
      imm = 1; wb = (op != 37); mr = (op == 36); mw = (op == 37); s2 = (op == 37);
      cmd = (op == 33) ? 4'd2 : 4'd0;
    end else if (op inside {40, 41, 42}) begin
      imm = 1; br = 2'(op - 39); s2 = (op == 41);
    end
  endfunction

  function automatic logic [XLEN-1:0] model_read(input int a, input bit we, input int wa,
                                                 input logic [XLEN-1:0] wv);
    if (a == 0) return '0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wv;
`endif
    return m_rf[a];
  endfunction

  // One clock: drive inputs, check stall, advance the model and queue the expected ID/EX.
  task automatic cycle(input bit r, iv, h, f, we, input logic [4:0] wa,
                       input logic [XLEN-1:0] wv, input logic [31:0] ins);
    bit wb, mr, mw, imm, s2, lu;
    logic [1:0] br; logic [3:0] cmd;
    int rs, rt, rd;
    exp_t nx;
    @(negedge clk);
    rst = r; if_valid = iv; hold = h; flush = f; wb_en = we; wb_addr = wa;
    wb_value = wv; inst = ins; pc_in = pc_cnt; pc_cnt += 32'd4;
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    model_decode(int'(ins[31:26]), wb, mr, mw, imm, s2, br, cmd);
    lu = iv && m_ex.valid && m_ex.mr && m_ex.dest != 5'd0 &&
         (int'(m_ex.dest) == rs || (s2 && int'(m_ex.dest) == rt));
    #1;
    if (m_known) chk("stall", 64'(stall), 64'(h || lu));
    nx = '{default: '0};
    if (r) begin
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
      m_known = 1'b1;
    end else if (h) begin
      nx = m_ex;
    end else if (!(f || lu || !iv)) begin
      nx.valid = 1'b1; nx.pc = pc_in; nx.wb = wb; nx.mr = mr; nx.mw = mw; nx.br = br;
      nx.cmd = cmd; nx.s2u = s2;
      nx.v1 = model_read(rs, we, int'(wa), wv);
      nx.st = model_read(rt, we, int'(wa), wv);
      nx.v2 = imm ? XLEN'($signed(ins[15:0])) : nx.st;
      nx.dest = imm ? 5'(rt) : 5'(rd); nx.s1 = 5'(rs); nx.s2 = 5'(rt);
    end
    if (!r && we && wa != 5'd0) m_rf[wa] = wv;
    m_ex = nx;
    q.push_back(nx);
    @(posedge clk);
  endtask

  // Monitor: every ID/EX update is popped and compared field by field.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", 64'(ex_valid), 64'(e.valid));
        chk("ex_pc", 64'(ex_pc), 64'(e.pc));
        chk("ex_wb_en", 64'(ex_wb_en), 64'(e.wb));
        chk("ex_mem_read", 64'(ex_mem_read), 64'(e.mr));
        chk("ex_mem_write", 64'(ex_mem_write), 64'(e.mw));
        chk("ex_br", 64'(ex_br), 64'(e.br));
        chk("ex_cmd", 64'(ex_cmd), 64'(e.cmd));
        chk("ex_val1", 64'(ex_val1), 64'(e.v1));
        chk("ex_val2", 64'(ex_val2), 64'(e.v2));
        chk("ex_st_val", 64'(ex_st_val), 64'(e.st));
        chk("ex_dest", 64'(ex_dest), 64'(e.dest));
        chk("ex_src1", 64'(ex_src1), 64'(e.s1));
        chk("ex_src2", 64'(ex_src2), 64'(e.s2));
        chk("ex_src2_used", 64'(ex_src2_used), 64'(e.s2u));
      end
    end
  end

  function automatic logic [31:0] rinst(input int op, rs, rt, rd);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] iinst(input int op, rs, rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  initial begin
    int ops[$] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 36, 36, 37, 40, 41, 42, 2, 63};
    logic [31:0] ri;
    logic [XLEN-1:0] exp_byp;
    m_ex = '{default: '0};
    rst = 1'b1; if_valid = 1'b0; hold = 1'b0; flush = 1'b0; wb_en = 1'b0;
    wb_addr = 5'd0; wb_value = '0; inst = 32'd0; pc_in = 32'd0;

    cycle(1, 0, 0, 0, 0, 5'd0, '0, 32'd0);
    cycle(1, 0, 0, 0, 0, 5'd0, '0, 32'd0);
    #2 chk("reset_valid", 64'(ex_valid), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    cycle(0, 0, 0, 0, 1, 5'd1, 32'd5, 32'd0);
    cycle(0, 0, 0, 0, 1, 5'd2, 32'd7, 32'd0);

    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 1, 2, 3));
    #2 chk("add_val1", 64'(ex_val1), 64'd5);
    chk("add_val2", 64'(ex_val2), 64'd7);
    chk("add_dest", 64'(ex_dest), 64'd3);
    chk("add_cmd_wb", 64'({ex_valid, ex_cmd, ex_wb_en}), 64'b1_0000_1);

    cycle(0, 1, 0, 0, 0, 5'd0, '0, iinst(32, 1, 4, 16'hFFFF));
    #2 chk("addi_val2", 64'(ex_val2), 64'hFFFF_FFFF);
    chk("addi_dest_s2u", 64'({ex_dest, ex_src2_used}), 64'({5'd4, 1'b0}));

    cycle(0, 1, 0, 0, 0, 5'd0, '0, iinst(36, 1, 5, 16'd0));
    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 5, 1, 6));
    #2 chk("lu_bubble", 64'(ex_valid), 64'd0);
    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 5, 1, 6));
    #2 chk("lu_issue", 64'({ex_valid, ex_src1}), 64'({1'b1, 5'd5}));

    cycle(0, 1, 0, 0, 0, 5'd0, '0, iinst(36, 1, 0, 16'd0));
    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 0, 1, 7));
    #2 chk("ld_r0_nostall", 64'(ex_valid), 64'd1);

    cycle(0, 1, 0, 1, 0, 5'd0, '0, rinst(3, 1, 2, 8));
    #2 chk("flush_bubble", 64'(ex_valid), 64'd0);

    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 1, 2, 11));
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 5'd0, '0, rinst(3, 2, 1, 12));
    #2 chk("hold_dest", 64'({ex_valid, ex_dest}), 64'({1'b1, 5'd11}));

`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'hAA;
`else
    exp_byp = 32'd7;
`endif
    cycle(0, 1, 0, 0, 1, 5'd2, 32'hAA, rinst(1, 1, 2, 9));
    #2 chk("wb_same_cycle", 64'(ex_val2), 64'(exp_byp));
    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 1, 2, 9));
    #2 chk("wb_next_decode", 64'(ex_val2), 64'hAA);

    cycle(0, 0, 0, 0, 1, 5'd0, 32'hFF, 32'd0);
    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 0, 0, 10));
    #2 chk("r0_zero", 64'({ex_val1, ex_val2}), 64'd0);

    for (int n = 0; n < 600; n++) begin
      ri = iinst(ops[$urandom_range(0, ops.size() - 1)], $urandom_range(0, 7),
                 $urandom_range(0, 7), 16'($urandom));
      ri[15:11] = 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 10, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), XLEN'($urandom), ri);
    end

    cycle(0, 1, 0, 0, 1, 5'd1, 32'h55, rinst(1, 1, 2, 13));
    cycle(1, 1, 0, 0, 0, 5'd0, '0, rinst(1, 1, 2, 14));
    #2 chk("midreset_valid", 64'(ex_valid), 64'd0);
    cycle(0, 1, 0, 0, 0, 5'd0, '0, rinst(1, 1, 2, 15));
    #2 chk("midreset_rf", 64'({ex_val1, ex_val2}), 64'd0);

    cycle(0, 0, 0, 0, 0, 5'd0, '0, 32'd0);
    #2 chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
